idu_pipe: RTL and testbench

IDU_PIPE -- requirements
Module: idu_pipe

---
 rtl/idu_pipe_pkg.sv | 34 +++
 rtl/idu_pipe_if.sv | 32 +++
 rtl/clo.sv | 21 ++
 rtl/idu_bundle_reg.sv | 32 +++
 rtl/idu_pipe.sv | 155 +++++++++++++++
 tb/tb_idu_pipe.sv | 276 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/idu_pipe_pkg.sv
// idu_pipe_pkg: slot payload widths and the occupancy encoding shared by the
// instruction-decode input buffer (idu_pipe) and its interface.
// The widths normally come from ncpu64k_config.vh on the include path; the
// guarded fallbacks below only apply when that header has not been read.
`ifndef NCPU_INSN_DW
`define NCPU_INSN_DW 32
`endif
`ifndef PC_W
`define PC_W 30
`endif
`ifndef FNT_EXC_W
`define FNT_EXC_W 4
`endif
`ifndef BPU_UPD_W
`define BPU_UPD_W 8
`endif

package idu_pipe_pkg;

  localparam int unsigned InsnDw  = `NCPU_INSN_DW;
  localparam int unsigned PcW     = `PC_W;
  localparam int unsigned ExcW    = `FNT_EXC_W;
  localparam int unsigned BpuUpdW = `BPU_UPD_W;
  // One slot's payload: {insn, pc, exc, bpu_upd}.
  localparam int unsigned SlotW   = InsnDw + PcW + ExcW + BpuUpdW;

  // StFull is only reachable when the two-entry skid buffer is built.
  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } occ_e;

endpackage

// File: rtl/idu_pipe_if.sv
// idu_pipe_if: fetch-queue side (id_*) and decode side (dec_*) of the ID buffer.
// slave is the buffer's view, master is the view of the surrounding pipeline.
interface idu_pipe_if #(
  parameter int unsigned P_IW = 0
);
  localparam int unsigned IW = 1 << P_IW;

  logic [IW-1:0]                          id_valid;
  logic [IW*idu_pipe_pkg::InsnDw-1:0]     id_ins;
  logic [IW*idu_pipe_pkg::PcW-1:0]        id_pc;
  logic [IW*idu_pipe_pkg::ExcW-1:0]       id_exc;
  logic [IW*idu_pipe_pkg::BpuUpdW-1:0]    id_bpu_upd;
  logic [P_IW:0]                          id_pop_cnt;

  logic [IW-1:0]                          dec_valid;
  logic [IW*idu_pipe_pkg::InsnDw-1:0]     dec_ins;
  logic [IW*idu_pipe_pkg::PcW-1:0]        dec_pc;
  logic [IW*idu_pipe_pkg::ExcW-1:0]       dec_exc;
  logic [IW*idu_pipe_pkg::BpuUpdW-1:0]    dec_bpu_upd;
  logic                                   dec_ready;

  modport slave (
    input  id_valid, id_ins, id_pc, id_exc, id_bpu_upd, dec_ready,
    output id_pop_cnt, dec_valid, dec_ins, dec_pc, dec_exc, dec_bpu_upd
  );

  modport master (
    output id_valid, id_ins, id_pc, id_exc, id_bpu_upd, dec_ready,
    input  id_pop_cnt, dec_valid, dec_ins, dec_pc, dec_exc, dec_bpu_upd
  );

endinterface

// File: rtl/clo.sv
// clo: count of consecutive ones starting at bit 0 (the lowest slot).
module clo #(
  parameter int unsigned Width = 1,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] din_i,
  output logic [CntW-1:0]  cnt_o
);

  // Count upwards from bit 0 and stop at the first zero.
  always_comb begin
    logic stop;
    stop  = 1'b0;
    cnt_o = '0;
    for (int i = 0; i < Width; i++) begin
      if (!stop && din_i[i]) cnt_o = cnt_o + CntW'(1);
      else                   stop  = 1'b1;
    end
  end

endmodule

// File: rtl/idu_bundle_reg.sv
// idu_bundle_reg: one buffered issue bundle (all slot payloads + valid mask).
module idu_bundle_reg #(
  parameter int unsigned PayloadW = 1,
  parameter int unsigned MaskW    = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [PayloadW-1:0] payload_i,
  input  logic [MaskW-1:0]    mask_i,
  output logic [PayloadW-1:0] payload_o,
  output logic [MaskW-1:0]    mask_o
);

  logic [PayloadW-1:0] payload_q;
  logic [MaskW-1:0]    mask_q;

  // Capture a whole bundle on load, hold it otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      payload_q <= '0;
      mask_q    <= '0;
    end else if (load_i) begin
      payload_q <= payload_i;
      mask_q    <= mask_i;
    end
  end

  assign payload_o = payload_q;
  assign mask_o    = mask_q;

endmodule

// File: rtl/idu_pipe.sv
// idu_pipe: buffers fetch bundles (valid prefix only) in front of decode.
// Build option IDU_PIPE_SKID_EN: two-entry skid buffer whose accept depends only
// on registered occupancy. Without it a single bundle register is used and a
// held bundle can be replaced in the cycle decode takes it (dec_ready feeds
// id_pop_cnt combinationally).
module idu_pipe
  import idu_pipe_pkg::*;
#(
  parameter int unsigned CONFIG_AW            = 0,
  parameter int unsigned CONFIG_P_ISSUE_WIDTH = 0
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  idu_pipe_if.slave idu_io
);

  localparam int unsigned IW       = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int unsigned PayloadW = IW * SlotW;

  // A PC slot can never be wider than the virtual address (0 = unchecked).
  if (CONFIG_AW != 0 && PcW > CONFIG_AW) begin : g_aw_chk
    $error("idu_pipe: PC_W exceeds CONFIG_AW");
  end

  logic [CONFIG_P_ISSUE_WIDTH:0] prefix;
  logic [IW-1:0]                 push_mask, head_mask, head_mask_d;
  logic [PayloadW-1:0]           push_payload, head_payload, head_payload_d;
  logic                          accept, push, deq, ld_head;
  occ_e                          state_q, state_d;
`ifdef IDU_PIPE_SKID_EN
  logic [IW-1:0]                 tail_mask;
  logic [PayloadW-1:0]           tail_payload;
  logic                          ld_tail, head_from_tail;
`endif

  clo #(
    .Width(IW)
  ) u_clo (
    .din_i(idu_io.id_valid),
    .cnt_o(prefix)
  );

  // Slot i is taken only if it and every slot below it are valid.
  always_comb begin
    logic run;
    run       = 1'b1;
    push_mask = '0;
    for (int i = 0; i < IW; i++) begin
      run          = run & idu_io.id_valid[i];
      push_mask[i] = run;
    end
  end

  assign push_payload = {idu_io.id_ins, idu_io.id_pc, idu_io.id_exc, idu_io.id_bpu_upd};

`ifdef IDU_PIPE_SKID_EN
  assign accept = (state_q != StFull);
`else
  assign accept = (state_q == StEmpty) || idu_io.dec_ready;
`endif

  // Nothing is popped from fetch during reset or flush.
  assign idu_io.id_pop_cnt = (rst && !flush && accept) ? prefix : '0;
  assign push              = |idu_io.id_pop_cnt;
  assign idu_io.dec_valid  = (state_q != StEmpty) ? head_mask : '0;
  assign deq               = idu_io.dec_ready && |idu_io.dec_valid;
  assign {idu_io.dec_ins, idu_io.dec_pc, idu_io.dec_exc, idu_io.dec_bpu_upd} = head_payload;

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StEmpty;
    else      state_q <= state_d;
  end

  // Next occupancy and entry load strobes; flush overrides push and dequeue.
  always_comb begin
    state_d = state_q;
    ld_head = 1'b0;
`ifdef IDU_PIPE_SKID_EN
    ld_tail        = 1'b0;
    head_from_tail = 1'b0;
`endif
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StOne;
            ld_head = 1'b1;
          end
        end
        StOne: begin
          if (push && deq) begin
            ld_head = 1'b1;
`ifdef IDU_PIPE_SKID_EN
          end else if (push) begin
            state_d = StFull;
            ld_tail = 1'b1;
`endif
          end else if (deq) begin
            state_d = StEmpty;
          end
        end
`ifdef IDU_PIPE_SKID_EN
        StFull: begin
          if (deq) begin
            state_d        = StOne;
            ld_head        = 1'b1;
            head_from_tail = 1'b1;
          end
        end
`endif
        default: state_d = StEmpty;
      endcase
    end
  end

`ifdef IDU_PIPE_SKID_EN
  // Head refills from the tail entry when the older bundle leaves a full buffer.
  assign head_payload_d = head_from_tail ? tail_payload : push_payload;
  assign head_mask_d    = head_from_tail ? tail_mask : push_mask;

  idu_bundle_reg #(
    .PayloadW(PayloadW),
    .MaskW   (IW)
  ) u_tail (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (ld_tail),
    .payload_i(push_payload),
    .mask_i   (push_mask),
    .payload_o(tail_payload),
    .mask_o   (tail_mask)
  );
`else
  assign head_payload_d = push_payload;
  assign head_mask_d    = push_mask;
`endif

  idu_bundle_reg #(
    .PayloadW(PayloadW),
    .MaskW   (IW)
  ) u_head (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (ld_head),
    .payload_i(head_payload_d),
    .mask_i   (head_mask_d),
    .payload_o(head_payload),
    .mask_o   (head_mask)
  );

endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: vector table, hand sequences for hold/flush/reset corners, then
// random traffic against a queue-based model of the buffer.
module tb_idu_pipe;
  import idu_pipe_pkg::*;

  localparam int unsigned P  = 2;
  localparam int unsigned IW = 1 << P;
`ifdef IDU_PIPE_SKID_EN
  localparam int unsigned Skid = 1;
`else
  localparam int unsigned Skid = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  idu_pipe_if #(.P_IW(P)) bus ();

  idu_pipe #(
    .CONFIG_AW           (0),
    .CONFIG_P_ISSUE_WIDTH(P)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .idu_io(bus)
  );

  typedef struct {
    logic [IW-1:0]         mask;
    logic [IW*InsnDw-1:0]  ins;
    logic [IW*PcW-1:0]     pc;
    logic [IW*ExcW-1:0]    exc;
    logic [IW*BpuUpdW-1:0] bpu;
  } bundle_t;

  typedef struct {
    logic [IW-1:0] iv;
    logic          rdy;
    logic          fl;
    int unsigned   exp_pop;
    logic [IW-1:0] exp_dv;
  } vec_t;

  bundle_t mq[$];
  vec_t    vec[10];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [IW-1:0] iv, input logic rdy, input logic fl);
    bus.id_valid  = iv;
    bus.dec_ready = rdy;
    flush         = fl;
    for (int s = 0; s < IW; s++) begin
      bus.id_ins[s*InsnDw +: InsnDw]       = InsnDw'($urandom);
      bus.id_pc[s*PcW +: PcW]              = PcW'($urandom);
      bus.id_exc[s*ExcW +: ExcW]           = ExcW'($urandom);
      bus.id_bpu_upd[s*BpuUpdW +: BpuUpdW] = BpuUpdW'($urandom);
    end
  endtask

  function automatic int unsigned prefix_len(input logic [IW-1:0] v);
    int unsigned n = 0;
    while (n < IW && v[n] === 1'b1) n++;
    return n;
  endfunction

  // Slots taken this cycle, from the current inputs and the model queue.
  function automatic int unsigned model_pop();
    bit room;
    room = (Skid != 0) ? (mq.size() < 2) : (mq.size() == 0 || bus.dec_ready);
    if (!rst || flush || !room) return 0;
    return prefix_len(bus.id_valid);
  endfunction

  task automatic model_update();
    int unsigned n;
    bundle_t     b;
    n = model_pop();
    if (!rst || flush) begin
      mq.delete();
      return;
    end
    if (bus.dec_ready && mq.size() != 0) void'(mq.pop_front());
    if (n != 0) begin
      b.mask = IW'((1 << n) - 1);
      b.ins  = bus.id_ins;
      b.pc   = bus.id_pc;
      b.exc  = bus.id_exc;
      b.bpu  = bus.id_bpu_upd;
      mq.push_back(b);
    end
  endtask

  task automatic model_check();
    logic [IW-1:0] exp_dv;
    chk("rand_pop_cnt", bus.id_pop_cnt, model_pop());
    exp_dv = (mq.size() != 0) ? mq[0].mask : '0;
    chk("rand_dec_valid", bus.dec_valid, exp_dv);
    if (mq.size() != 0) begin
      for (int s = 0; s < IW; s++) begin
        if (mq[0].mask[s]) begin
          chk("rand_dec_ins", bus.dec_ins[s*InsnDw +: InsnDw], mq[0].ins[s*InsnDw +: InsnDw]);
          chk("rand_dec_pc", bus.dec_pc[s*PcW +: PcW], mq[0].pc[s*PcW +: PcW]);
          chk("rand_dec_exc", bus.dec_exc[s*ExcW +: ExcW], mq[0].exc[s*ExcW +: ExcW]);
          chk("rand_dec_bpu", bus.dec_bpu_upd[s*BpuUpdW +: BpuUpdW],
              mq[0].bpu[s*BpuUpdW +: BpuUpdW]);
        end
      end
    end
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic end_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  logic [PcW-1:0] pc_a, pc_b;

  initial begin
    // Steady dec_ready=1 keeps at most one bundle held, so these rows hold for both builds.
    vec[0] = '{4'b1111, 1'b1, 1'b0, 4, 4'b0000};
    vec[1] = '{4'b1011, 1'b1, 1'b0, 2, 4'b1111};
    vec[2] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0011};
    vec[3] = '{4'b0001, 1'b1, 1'b0, 1, 4'b0000};
    vec[4] = '{4'b1110, 1'b1, 1'b0, 0, 4'b0001};
    vec[5] = '{4'b0111, 1'b1, 1'b1, 0, 4'b0000};
    vec[6] = '{4'b0111, 1'b1, 1'b0, 3, 4'b0000};
    vec[7] = '{4'b1111, 1'b1, 1'b1, 0, 4'b0111};
    vec[8] = '{4'b0011, 1'b1, 1'b0, 2, 4'b0000};
    vec[9] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0011};

    rst = 1'b0;
    set_in(4'b1111, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    to_check();
    chk("rst_pop_cnt", bus.id_pop_cnt, 0);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_payload_zero",
        |{bus.dec_ins, bus.dec_pc, bus.dec_exc, bus.dec_bpu_upd}, 0);
    model_update();
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int r = 0; r < 10; r++) begin
      set_in(vec[r].iv, vec[r].rdy, vec[r].fl);
      to_check();
      chk($sformatf("vec%0d_pop_cnt", r), bus.id_pop_cnt, vec[r].exp_pop);
      chk($sformatf("vec%0d_dec_valid", r), bus.dec_valid, vec[r].exp_dv);
      end_cycle();
    end

    // Decode stalled: hold bundles, then drain in order.
    set_in(4'b0001, 1'b0, 1'b0);
    pc_a = bus.id_pc[PcW-1:0];
    to_check();
    chk("hold1_pop_cnt", bus.id_pop_cnt, 1);
    chk("hold1_dec_valid", bus.dec_valid, 0);
    end_cycle();
    set_in(4'b0001, 1'b0, 1'b0);
    pc_b = bus.id_pc[PcW-1:0];
    to_check();
    chk("hold2_pop_cnt", bus.id_pop_cnt, Skid);
    chk("hold2_dec_valid", bus.dec_valid, 4'b0001);
    chk("hold2_dec_pc", bus.dec_pc[PcW-1:0], pc_a);
    end_cycle();
    set_in(4'b0001, 1'b0, 1'b0);
    to_check();
    chk("hold3_pop_cnt", bus.id_pop_cnt, 0);
    chk("hold3_dec_valid", bus.dec_valid, 4'b0001);
    end_cycle();
    set_in(4'b0000, 1'b1, 1'b0);
    to_check();
    chk("drain1_dec_valid", bus.dec_valid, 4'b0001);
    chk("drain1_dec_pc", bus.dec_pc[PcW-1:0], pc_a);
    end_cycle();
    set_in(4'b0000, 1'b1, 1'b0);
    to_check();
    chk("drain2_dec_valid", bus.dec_valid, Skid);
`ifdef IDU_PIPE_SKID_EN
    chk("drain2_dec_pc", bus.dec_pc[PcW-1:0], pc_b);
`endif
    end_cycle();
    set_in(4'b0000, 1'b1, 1'b0);
    to_check();
    chk("drain3_dec_valid", bus.dec_valid, 0);
    end_cycle();

    // Fill, then flush together with dec_ready.
    set_in(4'b1111, 1'b0, 1'b0);
    to_check();
    chk("fill1_pop_cnt", bus.id_pop_cnt, 4);
    end_cycle();
    set_in(4'b1111, 1'b0, 1'b0);
    to_check();
    chk("fill2_pop_cnt", bus.id_pop_cnt, 4 * Skid);
    end_cycle();
    set_in(4'b1111, 1'b1, 1'b1);
    to_check();
    chk("flush_pop_cnt", bus.id_pop_cnt, 0);
    chk("flush_dec_valid", bus.dec_valid, 4'b1111);
    end_cycle();
    set_in(4'b0000, 1'b1, 1'b0);
    to_check();
    chk("post_flush_dec_valid", bus.dec_valid, 0);
    end_cycle();

    // Held bundle replaced in the same cycle decode takes it.
    set_in(4'b0001, 1'b1, 1'b0);
    to_check();
    chk("swap1_pop_cnt", bus.id_pop_cnt, 1);
    end_cycle();
    set_in(4'b0111, 1'b1, 1'b0);
    pc_b = bus.id_pc[PcW-1:0];
    to_check();
    chk("swap2_pop_cnt", bus.id_pop_cnt, 3);
    chk("swap2_dec_valid", bus.dec_valid, 4'b0001);
    end_cycle();
    set_in(4'b0000, 1'b1, 1'b0);
    to_check();
    chk("swap3_dec_valid", bus.dec_valid, 4'b0111);
    chk("swap3_dec_pc", bus.dec_pc[PcW-1:0], pc_b);
    end_cycle();

    // Asynchronous reset while one bundle is held.
    set_in(4'b0001, 1'b0, 1'b0);
    to_check();
    end_cycle();
    set_in(4'b1111, 1'b0, 1'b0);
    #1;
    chk("arst_pre_dec_valid", bus.dec_valid, 4'b0001);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_dec_valid", bus.dec_valid, 0);
    chk("arst_pop_cnt", bus.id_pop_cnt, 0);
    to_check();
    end_cycle();
    rst = 1'b1;
    set_in(4'b0000, 1'b0, 1'b0);
    to_check();
    chk("arst_release_dec_valid", bus.dec_valid, 0);
    end_cycle();

    for (int c = 0; c < 400; c++) begin
      logic [IW-1:0] iv;
      iv = ($urandom_range(0, 2) == 0) ? '1 : IW'($urandom);
      set_in(iv, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      to_check();
      model_check();
      end_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
